// File: rtl/param_config_mode.sv
// rtl/param_config_mode.sv - ASCII decimal entry of NUM_PARAMS bounded fields over a byte link.
// Define SETTING_ECHO_EN to echo each accepted digit back to the sender.
module param_config_mode #(
  parameter int NUM_PARAMS     = 3,
  parameter int PARAM_WIDTH    = 4,
  parameter logic [NUM_PARAMS*PARAM_WIDTH-1:0] PARAM_DEFAULT = {4'd2, 4'd9, 4'd5},
  parameter logic [NUM_PARAMS*PARAM_WIDTH-1:0] PARAM_MIN     = {4'd1, 4'd0, 4'd1},
  parameter logic [NUM_PARAMS*PARAM_WIDTH-1:0] PARAM_MAX     = {4'd5, 4'd9, 4'd5},
  parameter int DIGIT_MAX      = 2,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mode_active,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_done,
  output logic                              clear_rx_buffer,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic [NUM_PARAMS*PARAM_WIDTH-1:0] cfg_out,
  output logic                              cfg_valid,
  output logic [2:0]                        param_idx,
  output logic [3:0]                        error_code,
  output logic [3:0]                        sub_state
);

  localparam int CFG_W = NUM_PARAMS * PARAM_WIDTH;
  localparam int ACC_W = PARAM_WIDTH + 4;
  localparam int CNT_W = $clog2(DIGIT_MAX + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIGIT_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_PARAMS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RECV    = 4'd1,
    S_CHECK   = 4'd2,
    S_NACK    = 4'd3,
`ifdef SETTING_ECHO_EN
    S_ECHO    = 4'd4,
`endif
    S_CONFIRM = 4'd5,
    S_DONE    = 4'd6
  } state_t;

  state_t                 state_q, state_n;
  logic [CFG_W-1:0]       shadow_q, shadow_n, cfg_n;
  logic [ACC_W-1:0]       acc_q, acc_n, acc_sat;
  logic [ACC_W+3:0]       acc_prod;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [TMO_W-1:0]       tmo_q, tmo_n;
  logic [2:0]             idx_n;
  logic [3:0]             err_n;
  logic                   clr_n, valid_n, advance, send_req;
  logic                   is_digit, is_term, in_range;
  logic [PARAM_WIDTH-1:0] fld_min, fld_max;
`ifdef SETTING_ECHO_EN
  logic [7:0]             echo_q, echo_n;
`endif

  assign sub_state = state_q;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term   = (rx_data == 8'h20) || (rx_data == 8'h0D);
  assign acc_prod  = (ACC_W+4)'(acc_q) * (ACC_W+4)'(10) + (ACC_W+4)'(rx_data[3:0]);
  assign acc_sat   = (acc_prod > (ACC_W+4)'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : acc_prod[ACC_W-1:0];
  assign in_range  = (ACC_W'(fld_min) <= acc_q) && (acc_q <= ACC_W'(fld_max));

  always_comb begin
    fld_min = '0;
    fld_max = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (param_idx == 3'(i)) begin
        fld_min = PARAM_MIN[i*PARAM_WIDTH +: PARAM_WIDTH];
        fld_max = PARAM_MAX[i*PARAM_WIDTH +: PARAM_WIDTH];
      end
    end
  end

  // Transmit only from the three send states; a busy transmitter just stalls the state.
  always_comb begin
    send_req = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_NACK:    begin send_req = 1'b1; tx_data = (error_code == 4'd4) ? 8'h54 : 8'h3F; end
      S_CONFIRM: begin send_req = 1'b1; tx_data = 8'h53; end
`ifdef SETTING_ECHO_EN
      S_ECHO:    begin send_req = 1'b1; tx_data = echo_q; end
`endif
      default:   ;
    endcase
    tx_start = send_req && !tx_busy && mode_active;
  end

  always_comb begin
    state_n  = state_q;
    shadow_n = shadow_q;
    cfg_n    = cfg_out;
    acc_n    = acc_q;
    cnt_n    = cnt_q;
    idx_n    = param_idx;
    err_n    = error_code;
    tmo_n    = '0;
    clr_n    = 1'b0;
    valid_n  = 1'b0;
    advance  = 1'b0;
`ifdef SETTING_ECHO_EN
    echo_n   = echo_q;
`endif
    if (!mode_active) begin
      state_n  = S_IDLE;
      shadow_n = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          shadow_n = cfg_out;
          idx_n    = 3'd0;
          acc_n    = '0;
          cnt_n    = '0;
          err_n    = 4'd0;
          state_n  = S_RECV;
        end
        S_RECV: begin
          if (rx_done) begin
            clr_n = 1'b1;
            if (is_digit) begin
              if (cnt_q == CNT_LIMIT) begin
                err_n   = 4'd3;
                state_n = S_NACK;
              end else begin
                acc_n = acc_sat;
                cnt_n = cnt_q + CNT_W'(1);
`ifdef SETTING_ECHO_EN
                echo_n  = rx_data;
                state_n = S_ECHO;
`endif
              end
            end else if (is_term) begin
              if (cnt_q != '0) state_n = S_CHECK;
              else             advance = 1'b1;
            end else begin
              err_n   = 4'd1;
              state_n = S_NACK;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_n   = 4'd4;
            state_n = S_NACK;
          end else begin
            tmo_n = tmo_q + TMO_W'(1);
          end
        end
        S_CHECK: begin
          if (in_range) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
              if (param_idx == 3'(i)) shadow_n[i*PARAM_WIDTH +: PARAM_WIDTH] = acc_q[PARAM_WIDTH-1:0];
            end
            advance = 1'b1;
          end else begin
            err_n   = 4'd2;
            state_n = S_NACK;
          end
        end
        S_NACK: begin
          if (tx_start) begin
            acc_n = '0;
            cnt_n = '0;
            if (error_code == 4'd4) begin
              shadow_n = '0;
              state_n  = S_DONE;
            end else begin
              state_n = S_RECV;
            end
          end
        end
`ifdef SETTING_ECHO_EN
        S_ECHO: if (tx_start) state_n = S_RECV;
`endif
        S_CONFIRM: begin
          if (tx_start) begin
            cfg_n   = shadow_q;
            valid_n = 1'b1;
            state_n = S_DONE;
          end
        end
        default: ;
      endcase
      if (advance) begin
        acc_n = '0;
        cnt_n = '0;
        if (param_idx == IDX_LAST) begin
          state_n = S_CONFIRM;
        end else begin
          idx_n   = param_idx + 3'd1;
          state_n = S_RECV;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      shadow_q        <= '0;
      cfg_out         <= PARAM_DEFAULT;
      acc_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      param_idx       <= 3'd0;
      error_code      <= 4'd0;
      clear_rx_buffer <= 1'b0;
      cfg_valid       <= 1'b0;
`ifdef SETTING_ECHO_EN
      echo_q          <= 8'h00;
`endif
    end else begin
      state_q         <= state_n;
      shadow_q        <= shadow_n;
      cfg_out         <= cfg_n;
      acc_q           <= acc_n;
      cnt_q           <= cnt_n;
      tmo_q           <= tmo_n;
      param_idx       <= idx_n;
      error_code      <= err_n;
      clear_rx_buffer <= clr_n;
      cfg_valid       <= valid_n;
`ifdef SETTING_ECHO_EN
      echo_q          <= echo_n;
`endif
    end
  end

endmodule

// File: tb/tb_param_config_mode.sv
// tb/tb_param_config_mode.sv - Directed-vector bench for param_config_mode with a short receive timeout.
module tb_param_config_mode;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_active = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        clear_rx_buffer;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [11:0] cfg_out;
  logic        cfg_valid;
  logic [2:0]  param_idx;
  logic [3:0]  error_code;
  logic [3:0]  sub_state;

  int          n_vec = 0;
  int          n_miss = 0;
  int          valid_cnt = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  echo_q[$];

  param_config_mode #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mode_active(mode_active),
    .rx_data(rx_data), .rx_done(rx_done), .clear_rx_buffer(clear_rx_buffer),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .param_idx(param_idx),
    .error_code(error_code), .sub_state(sub_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] last_tx();
    return (tx_q.size() > 0) ? tx_q[tx_q.size()-1] : 8'h00;
  endfunction

  always @(negedge clk) begin
    if (tx_start) begin
      check_eq("tx_while_busy", {31'd0, tx_busy}, 0);
      check_eq("tx_start_width", {31'd0, prev_start}, 0);
      if (tx_data >= 8'h30 && tx_data <= 8'h39) echo_q.push_back(tx_data);
      else tx_q.push_back(tx_data);
    end
    prev_start = tx_start;
    if (cfg_valid) valid_cnt++;
  end

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while (sub_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {28'd0, sub_state}, {28'd0, s});
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_state(4'd1, 40, "wait_recv");
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
    @(negedge clk);
    check_eq("clr_pulse", {31'd0, clear_rx_buffer}, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic restart();
    mode_active = 1'b0;
    repeat (2) @(negedge clk);
    tx_q.delete();
    echo_q.delete();
    valid_cnt = 0;
    mode_active = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_state", sub_state, 0);
    check_eq("rst_cfg", cfg_out, 12'h295);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_clr", clear_rx_buffer, 0);
    check_eq("rst_valid", cfg_valid, 0);
    check_eq("rst_err", error_code, 0);
    check_eq("rst_idx", param_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full entry: three in-range fields, commit with 'S'
    mode_active = 1'b1;
    send_str("3 ");
    send_str("9 ");
    send_str("4");
    send_byte(8'h0D);
    wait_state(4'd6, 20, "ok_done");
    repeat (2) @(negedge clk);
    check_eq("ok_cfg", cfg_out, 12'h493);
    check_eq("ok_valid_cnt", valid_cnt, 1);
    check_eq("ok_err", error_code, 0);
    check_eq("ok_ntx", tx_q.size(), 1);
    check_eq("ok_tx", last_tx(), 8'h53);

    // Abort mid-entry, then asynchronous reset
    restart();
    send_str("3 ");
    wait_state(4'd1, 20, "abort_recv");
    check_eq("abort_idx", param_idx, 1);
    mode_active = 1'b0;
    @(negedge clk);
    check_eq("abort_state", sub_state, 0);
    check_eq("abort_cfg", cfg_out, 12'h493);
    check_eq("abort_tx_start", tx_start, 0);
    rst_n = 1'b0;
    #1;
    check_eq("areset_cfg", cfg_out, 12'h295);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Out-of-range field 0, retry, then skip remaining fields with CR
    restart();
    send_str("7 ");
    wait_state(4'd1, 20, "range_back");
    repeat (2) @(negedge clk);
    check_eq("range_err", error_code, 2);
    check_eq("range_cfg", cfg_out, 12'h295);
    check_eq("range_tx", last_tx(), 8'h3F);
    check_eq("range_idx", param_idx, 0);
    send_str("5 ");
    send_byte(8'h0D);
    send_byte(8'h0D);
    wait_state(4'd6, 20, "range_done");
    repeat (2) @(negedge clk);
    check_eq("range_cfg2", cfg_out, 12'h295);
    check_eq("range_valid_cnt", valid_cnt, 1);
    check_eq("range_tx2", last_tx(), 8'h53);
    check_eq("range_err_held", error_code, 2);

    // Bad character, then digit overflow
    restart();
    send_str("1x");
    wait_state(4'd1, 20, "badch_back");
    @(negedge clk);
    check_eq("badch_err", error_code, 1);
    check_eq("badch_tx", last_tx(), 8'h3F);
    send_str("123");
    wait_state(4'd1, 20, "ovf_back");
    @(negedge clk);
    check_eq("ovf_err", error_code, 3);
    check_eq("ovf_ntx", tx_q.size(), 2);
    check_eq("ovf_idx", param_idx, 0);

    // Idle receive timeout
    restart();
    repeat (40) @(negedge clk);
    check_eq("tmo_early_state", sub_state, 1);
    check_eq("tmo_early_ntx", tx_q.size(), 0);
    wait_state(4'd6, 40, "tmo_done");
    repeat (2) @(negedge clk);
    check_eq("tmo_err", error_code, 4);
    check_eq("tmo_tx", last_tx(), 8'h54);
    check_eq("tmo_valid_cnt", valid_cnt, 0);
    check_eq("tmo_cfg", cfg_out, 12'h295);

`ifdef SETTING_ECHO_EN
    // Echo held off by a busy transmitter
    restart();
    tx_busy = 1'b1;
    send_byte(8'h33);
    repeat (10) @(negedge clk);
    check_eq("echo_held_n", echo_q.size(), 0);
    check_eq("echo_held_state", sub_state, 4);
    tx_busy = 1'b0;
    wait_state(4'd1, 10, "echo_back");
    @(negedge clk);
    check_eq("echo_n", echo_q.size(), 1);
    check_eq("echo_byte", (echo_q.size() > 0) ? echo_q[0] : 8'h00, 8'h33);
    send_str(" ");
    send_str("9 ");
    send_str("4");
    send_byte(8'h0D);
    wait_state(4'd6, 20, "echo_done");
    repeat (2) @(negedge clk);
    check_eq("echo_cfg", cfg_out, 12'h493);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/param_config_mode.md
PARAM_CONFIG_MODE -- requirements
Module: param_config_mode

Interface
REQ-001 SHALL have parameter NUM_PARAMS, default 3, number of configurable fields (1..8).
REQ-002 SHALL have parameter PARAM_WIDTH, default 4, bits per field.
REQ-003 SHALL have parameter PARAM_DEFAULT, default {4'd2,4'd9,4'd5}, flattened reset values; field 0 in the LSBs (max_dim=5, max_value=9, matrices_per_size=2).
REQ-004 SHALL have parameter PARAM_MIN, default {4'd1,4'd0,4'd1}, flattened inclusive lower limits.
REQ-005 SHALL have parameter PARAM_MAX, default {4'd5,4'd9,4'd5}, flattened inclusive upper limits.
REQ-006 SHALL have parameter DIGIT_MAX, default 2, maximum decimal digits per field.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 100000000, receive idle limit.
REQ-008 clk  in  1  clock; all state changes on its rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 mode_active  in  1  enables block; low forces IDLE.
REQ-011 rx_data  in  8  received ASCII byte, valid when rx_done high.
REQ-012 rx_done  in  1  one-cycle byte strobe.
REQ-013 clear_rx_buffer  out  1  one-cycle pulse acknowledging a consumed byte.
REQ-014 tx_data  out  8  byte to transmit, held stable while tx_start high.
REQ-015 tx_start  out  1  one-cycle transmit request.
REQ-016 tx_busy  in  1  transmitter busy.
REQ-017 cfg_out  out  NUM_PARAMS*PARAM_WIDTH  committed configuration.
REQ-018 cfg_valid  out  1  one-cycle pulse on commit.
REQ-019 param_idx  out  3  field currently being entered.
REQ-020 error_code  out  4  0 none, 1 bad char, 2 range, 3 digit overflow, 4 timeout.
REQ-021 sub_state  out  4  IDLE=0, RECV=1, CHECK=2, NACK=3, ECHO=4, CONFIRM=5, DONE=6.

Function
REQ-022 IDLE: on mode_active, copy cfg_out to shadow, set param_idx=0, clear accumulator, digit count and error_code, go to RECV.
REQ-023 RECV: bytes are sampled only in RECV when rx_done is high; each sampled byte pulses clear_rx_buffer the following cycle.
REQ-024 Digit '0'..'9': accumulator=acc*10+digit, PARAM_WIDTH+4 bits, saturating at all-ones; count+1; a DIGIT_MAX+1-th digit sets error 3 and goes to NACK.
REQ-025 Terminator 0x20 or 0x0D with count>0 goes to CHECK; with count=0 keeps the shadow field unchanged and advances the field.
REQ-026 Any other byte sets error 1 and goes to NACK.
REQ-027 CHECK: PARAM_MIN[idx]<=acc<=PARAM_MAX[idx] writes the shadow field and advances; otherwise sets error 2 and goes to NACK.
REQ-028 Advance: clears the accumulator and count; idx+1 returns to RECV; after the last field goes to CONFIRM.
REQ-029 NACK: when !tx_busy sends '?', clears the accumulator and count, returns to RECV on the same field, and keeps error_code.
REQ-030 CONFIRM: when !tx_busy sends 'S', copies shadow to cfg_out, pulses cfg_valid, and goes to DONE.
REQ-031 DONE holds until mode_active falls; error_code holds until the next entry.
REQ-032 Timeout: a counter resets on every sampled byte and on RECV entry; reaching TIMEOUT_CYCLES in RECV sets error 4, sends 'T' when !tx_busy, discards the shadow, and goes to DONE without commit.
REQ-033 mode_active low in any state: next cycle goes to IDLE, discards the shadow, leaves cfg_out unchanged, and forces tx_start low.
REQ-034 tx_start SHALL never be asserted while tx_busy is high and SHALL never last more than 1 cycle.
REQ-035 rx_done in the same cycle as a timeout: the byte wins and the counter resets.

Reset
REQ-036 Reset: sub_state=IDLE, cfg_out=PARAM_DEFAULT, tx_start=0, tx_data=0, clear_rx_buffer=0, cfg_valid=0, error_code=0, param_idx=0, shadow and accumulator=0, timeout counter=0.
REQ-037 Mid-operation reset aborts without commit; cfg_out returns to PARAM_DEFAULT.

Configuration
REQ-038 Macro SETTING_ECHO_EN defined: each accepted digit enters ECHO, which sends the same byte when !tx_busy and then returns to RECV; bytes arriving during ECHO are dropped without clear_rx_buffer.
REQ-039 Macro SETTING_ECHO_EN undefined: the ECHO state is absent; digits stay in RECV and there is no echo traffic.

Verification
REQ-040 "3 ","9 ","4\r", tx_busy=0 -> one 'S', cfg_out={4,9,3}, cfg_valid one pulse, error_code=0.
REQ-041 "7 " on field 0 -> '?', error=2, cfg_out unchanged; then "5 ","\r","\r" -> 'S', cfg_out={2,9,5}.
REQ-042 "1x" -> '?', error=1 after 'x'; "123" -> '?', error=3 on the third digit.
REQ-043 No bytes for TIMEOUT_CYCLES (TIMEOUT_CYCLES=50 in bench) -> 'T', error=4, no cfg_valid.
REQ-044 mode_active dropped after "3 " -> IDLE next cycle, cfg_out unchanged; rst_n pulse -> cfg_out={2,9,5}.
REQ-045 SETTING_ECHO_EN defined, "3 " with tx_busy high 10 cycles -> '3' echoed after tx_busy falls, then normal flow.
